mem_stage_lsu: RTL and testbench

//   Parametrised successor of the MEM stage. Contains the EX/MEM pipeline register with stall-hold.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/mem_stage_lsu.sv | 144 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the MEM stage: load/store size codes,
// result-source selector, MEM FSM states and the EX/MEM bundle.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RES_MEM = 2'b01;

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
    } ex_mem_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for loads and stores: write enables, replicated
// store data, load extract with sign/zero extension, misalign flag.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]        addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rword_i,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              misalign_o
);

    logic        is_byte;
    logic        is_half;
    logic        is_uns;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Size decode; unknown funct3 codes fall through to word access
    always_comb begin
        is_byte    = (funct3_i == F3_LB) || (funct3_i == F3_LBU);
        is_half    = (funct3_i == F3_LH) || (funct3_i == F3_LHU);
        is_uns     = (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
        rbyte      = rword_i[{addr_i, 3'b000} +: 8];
        rhalf      = rword_i[{addr_i[1], 4'b0000} +: 16];
        be_o       = '1;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = 1'b0;
        if (is_byte) begin
            be_o    = (XLEN/8)'(1) << addr_i;
            wdata_o = {(XLEN/8){wdata_i[7:0]}};
            rdata_o = {{(XLEN-8){~is_uns & rbyte[7]}}, rbyte};
        end else if (is_half) begin
            be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {(XLEN/16){wdata_i[15:0]}};
            rdata_o    = {{(XLEN-16){~is_uns & rhalf[15]}}, rhalf};
            misalign_o = addr_i[0];
        end else begin
            misalign_o = (addr_i != 2'b00);
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: EX/MEM register with stall-hold, byte-lane data
// memory and a latency FSM that stalls upstream on multi-cycle loads.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] ReadDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic            StallM,
    output logic            MisalignM
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = XLEN / 8;
    localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    ex_mem_t         em_q, em_d;
    mem_state_t      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic [AW-1:0]    idx;
    logic [LANES-1:0] be;
    logic [XLEN-1:0]  st_word;
    logic [XLEN-1:0]  ld_word;
    logic             misalign;
    logic             is_load;
    logic             rd_valid;
    logic             stall;

    // Upper address bits are dropped so accesses wrap around the array
    assign idx     = em_q.alu_result[AW+1:2];
    assign is_load = (em_q.result_src == RES_MEM) && !em_q.mem_write;

    lsu_align u_align (
        .addr_i     (em_q.alu_result[1:0]),
        .funct3_i   (em_q.funct3),
        .wdata_i    (em_q.write_data),
        .rword_i    (mem_q[idx]),
        .be_o       (be),
        .wdata_o    (st_word),
        .rdata_o    (ld_word),
        .misalign_o (misalign)
    );

    // EX/MEM capture; the whole bundle holds while MEM is busy
    always_comb begin
        em_d = em_q;
        if (!stall) begin
            em_d.reg_write  = RegWriteE;
            em_d.mem_write  = MemWriteE;
            em_d.result_src = ResultSrcE;
            em_d.funct3     = Funct3E;
            em_d.alu_result = ALUResultE;
            em_d.write_data = WriteDataE;
            em_d.pc_plus4   = PCPlus4E;
            em_d.rd         = RdE;
        end
    end

    // Load latency FSM: one IDLE stall cycle then WAIT counts down to release
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        rd_valid = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (is_load && !misalign) begin
                    if (RD_LAT == 0) begin
                        rd_valid = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = MEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rd_valid = 1'b1;
                    state_d  = MEM_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    // Pipeline register and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            em_q    <= '0;
            state_q <= MEM_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            em_q    <= em_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store write at the end of the M cycle; untouched lanes keep old bytes
    always_ff @(posedge clk) begin
        if (em_q.mem_write && !misalign) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

    assign RegWriteM  = em_q.reg_write & ~(is_load & misalign);
    assign MemWriteM  = em_q.mem_write;
    assign ResultSrcM = em_q.result_src;
    assign ALUResultM = em_q.alu_result;
    assign ReadDataM  = rd_valid ? ld_word : '0;
    assign PCPlus4M   = em_q.pc_plus4;
    assign WriteDataM = em_q.write_data;
    assign RdM        = em_q.rd;
    assign StallM     = stall;
    assign MisalignM  = misalign & (is_load | em_q.mem_write);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu: one zero-latency and one
// three-cycle-latency instance checked against a byte-array model.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        stall;
        logic        mis;
    } out_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    op_t  e0, e3;
    out_t o0, o3;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] mdl [2][1024];

    always #5 clk = ~clk;

    mem_stage_lsu #(.DEPTH(256), .RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst0),
        .RegWriteE(e0.rw), .MemWriteE(e0.mw), .ResultSrcE(e0.rs),
        .Funct3E(e0.f3), .ALUResultE(e0.alu), .WriteDataE(e0.wd),
        .PCPlus4E(e0.pc), .RdE(e0.rd),
        .RegWriteM(o0.rw), .MemWriteM(o0.mw), .ResultSrcM(o0.rs),
        .ALUResultM(o0.alu), .ReadDataM(o0.rdata), .PCPlus4M(o0.pc),
        .WriteDataM(o0.wd), .RdM(o0.rd), .StallM(o0.stall),
        .MisalignM(o0.mis)
    );

    mem_stage_lsu #(.DEPTH(256), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3),
        .RegWriteE(e3.rw), .MemWriteE(e3.mw), .ResultSrcE(e3.rs),
        .Funct3E(e3.f3), .ALUResultE(e3.alu), .WriteDataE(e3.wd),
        .PCPlus4E(e3.pc), .RdE(e3.rd),
        .RegWriteM(o3.rw), .MemWriteM(o3.mw), .ResultSrcM(o3.rs),
        .ALUResultM(o3.alu), .ReadDataM(o3.rdata), .PCPlus4M(o3.pc),
        .WriteDataM(o3.wd), .RdM(o3.rd), .StallM(o3.stall),
        .MisalignM(o3.mis)
    );

    task automatic check(string tag, logic [191:0] got, logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(logic [2:0] f3, logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(int d, logic [2:0] f3,
                                             logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = nbytes(f3);
        v  = 32'd0;
        if (is_mis(f3, a)) return 32'd0;
        for (int i = 0; i < nb; i++)
            v = v | (32'(mdl[d][(a + i) % 1024]) << (8 * i));
        if (nb < 4 && !f3[2] && v[8*nb-1])
            v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic mdl_store(int d, logic [2:0] f3, logic [31:0] a,
                             logic [31:0] wd);
        if (is_mis(f3, a)) return;
        for (int i = 0; i < nbytes(f3); i++)
            mdl[d][(a + i) % 1024] = 8'(wd >> (8 * i));
    endtask

    // kind: 0 = ALU op, 1 = store, 2 = load
    function automatic op_t mk(int kind, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd);
        op_t o;
        o.rw  = (kind != 1);
        o.mw  = (kind == 1);
        o.rs  = (kind == 2) ? 2'b01 : 2'b00;
        o.f3  = f3;
        o.alu = a;
        o.wd  = wd;
        o.pc  = $urandom;
        o.rd  = 5'($urandom);
        return o;
    endfunction

    function automatic op_t rnd_op();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 63));
        return mk($urandom_range(0, 2), 3'($urandom_range(0, 7)), a, $urandom);
    endfunction

    task automatic verify(int d, op_t op);
        out_t o;
        bit   ld;
        bit   m;
        o  = (d != 0) ? o3 : o0;
        ld = (op.rs == 2'b01) && !op.mw;
        m  = (ld || op.mw) && is_mis(op.f3, op.alu);
        check("rd", o.rd, op.rd);
        check("alu", o.alu, op.alu);
        check("pc", o.pc, op.pc);
        check("wdata", o.wd, op.wd);
        check("memwrite", o.mw, op.mw);
        check("regwrite", o.rw, op.rw && !(ld && m));
        check("misalign", o.mis, m);
        check("stall", o.stall, 1'b0);
        if (ld) check("rdata", o.rdata, mdl_load(d, op.f3, op.alu));
        if (op.mw) mdl_store(d, op.f3, op.alu, op.wd);
    endtask

    task automatic run0(op_t op);
        e0 = op;
        @(negedge clk);
        verify(0, op);
    endtask

    task automatic run3(op_t op);
        int stalls;
        bit lw;
        stalls = 0;
        lw = (op.rs == 2'b01) && !op.mw && !is_mis(op.f3, op.alu);
        e3 = op;
        @(negedge clk);
        while (o3.stall && stalls < 20) begin
            check("hold_rd", o3.rd, op.rd);
            check("hold_alu", o3.alu, op.alu);
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", stalls, lw ? 3 : 0);
        verify(1, op);
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        e0   = '0;
        e3   = '0;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 1024; b++) mdl[d][b] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset0", o0, '0);
        check("reset3", o3, '0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        for (int w = 0; w < 256; w++) run0(mk(1, F3_LW, 32'(w * 4), 32'd0));
        for (int w = 0; w < 256; w++) run3(mk(1, F3_LW, 32'(w * 4), 32'd0));

        run0(mk(1, F3_LW, 32'h10, 32'hDEAD_BEEF));
        run0(mk(2, F3_LW, 32'h10, 32'd0));
        check("t1_lw", o0.rdata, 32'hDEAD_BEEF);
        run0(mk(1, F3_LB, 32'h11, 32'h0000_007F));
        run0(mk(2, F3_LW, 32'h10, 32'd0));
        check("t2_lw", o0.rdata, 32'hDEAD_7FEF);
        run0(mk(2, F3_LB, 32'h12, 32'd0));
        check("t2_lb", o0.rdata, 32'hFFFF_FFAD);
        run0(mk(2, F3_LBU, 32'h12, 32'd0));
        check("t2_lbu", o0.rdata, 32'h0000_00AD);
        run0(mk(1, F3_LH, 32'h12, 32'h0000_8001));
        run0(mk(2, F3_LH, 32'h12, 32'd0));
        check("t3_lh", o0.rdata, 32'hFFFF_8001);
        run0(mk(2, F3_LHU, 32'h12, 32'd0));
        check("t3_lhu", o0.rdata, 32'h0000_8001);
        run0(mk(1, F3_LH, 32'h13, 32'h0000_5555));
        check("t3_sh_mis", o0.mis, 1'b1);
        run0(mk(2, F3_LW, 32'h10, 32'd0));
        check("t3_unchanged", o0.rdata, 32'h8001_7FEF);
        run0(mk(1, F3_LW, 32'h400, 32'h1234_5678));
        run0(mk(2, F3_LW, 32'h000, 32'd0));
        check("t6_alias", o0.rdata, 32'h1234_5678);
        run0(mk(2, F3_LW, 32'h002, 32'd0));
        check("t6_mis", o0.mis, 1'b1);
        check("t6_regwrite", o0.rw, 1'b0);
        for (int i = 0; i < 300; i++) run0(rnd_op());
        e0 = '0;

        run3(mk(1, F3_LW, 32'h10, 32'hDEAD_BEEF));
        run3(mk(2, F3_LW, 32'h10, 32'd0));
        check("t4_lw", o3.rdata, 32'hDEAD_BEEF);
        run3(mk(2, F3_LH, 32'h12, 32'd0));
        run3(mk(2, F3_LBU, 32'h11, 32'd0));

        e3 = mk(2, F3_LW, 32'h10, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_wait_stall", o3.stall, 1'b1);
        rst3 = 1'b1;
        e3   = '0;
        @(negedge clk);
        check("t5_reset", o3, '0);
        rst3 = 1'b0;
        run3(mk(2, F3_LW, 32'h10, 32'd0));
        check("t5_after", o3.rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 150; i++) run3(rnd_op());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
